// File: rtl/fb_pkg.sv
// Framebuffer shared definitions: display geometry, coordinate widths,
// the pixel record carried through the write FIFO and the arbiter states.
package fb_pkg;

    localparam int unsigned RESOLUTION_H = 1280;
    localparam int unsigned RESOLUTION_V = 960;
    localparam int unsigned H_FRONT      = 80;
    localparam int unsigned H_SYNC       = 136;
    localparam int unsigned H_BACK       = 216;
    localparam int unsigned V_BOTTOM     = 1;
    localparam int unsigned V_SYNC       = 3;
    localparam int unsigned V_TOP        = 30;

    // Coordinate wires are sized for the full raster, blanking included.
    localparam int unsigned X_WIRE_WIDTH = $clog2(RESOLUTION_H + H_FRONT + H_SYNC + H_BACK);
    localparam int unsigned Y_WIRE_WIDTH = $clog2(RESOLUTION_V + V_BOTTOM + V_SYNC + V_TOP);

    typedef struct packed {
        logic [X_WIRE_WIDTH-1:0] hpos;
        logic [Y_WIRE_WIDTH-1:0] vpos;
        logic [2:0]              rgb;
    } pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BURST0 = 2'd1,
        ST_BURST1 = 2'd2
    } arb_state_t;

    // One-hot burst owner for a given arbiter state; zero when idle.
    function automatic logic [1:0] owner_of(arb_state_t s);
        case (s)
            ST_BURST0: return 2'b01;
            ST_BURST1: return 2'b10;
            default:   return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/pixel_clip.sv
// On-screen test for a pixel coordinate. Pure combinational so the drawing
// engine can reuse it in front of its own pipeline.
module pixel_clip #(
    parameter int unsigned RESOLUTION_H = 1280,
    parameter int unsigned RESOLUTION_V = 960,
    parameter int unsigned X_WIRE_WIDTH = 11,
    parameter int unsigned Y_WIRE_WIDTH = 10
) (
    input  logic [X_WIRE_WIDTH-1:0] hpos,
    input  logic [Y_WIRE_WIDTH-1:0] vpos,
    output logic                    on_screen
);

    // Widened to 32 bits so the compare is unsigned and never truncates a limit.
    assign on_screen = (32'(hpos) < RESOLUTION_H) && (32'(vpos) < RESOLUTION_V);

endmodule

// File: rtl/pixel_write_arbiter.sv
// Two-producer front end for the pixel-write FIFO: round-robin arbitration
// with burst locking, off-screen clipping and a saturating drop counter.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   ST_IDLE   | no burst open; arbitrate between requesters
//   ST_BURST0 | requester 0 holds the port until its last beat
//   ST_BURST1 | requester 1 holds the port until its last beat
module pixel_write_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned RESOLUTION_H = fb_pkg::RESOLUTION_H,
    parameter int unsigned RESOLUTION_V = fb_pkg::RESOLUTION_V,
    parameter int unsigned H_FRONT      = fb_pkg::H_FRONT,
    parameter int unsigned H_SYNC       = fb_pkg::H_SYNC,
    parameter int unsigned H_BACK       = fb_pkg::H_BACK,
    parameter int unsigned V_BOTTOM     = fb_pkg::V_BOTTOM,
    parameter int unsigned V_SYNC       = fb_pkg::V_SYNC,
    parameter int unsigned V_TOP        = fb_pkg::V_TOP,
    parameter int unsigned X_WIRE_WIDTH = $clog2(RESOLUTION_H + H_FRONT + H_SYNC + H_BACK),
    parameter int unsigned Y_WIRE_WIDTH = $clog2(RESOLUTION_V + V_BOTTOM + V_SYNC + V_TOP),
    parameter int unsigned DROP_CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   req_valid,
    input  logic [1:0]                   req_last,
    input  logic [1:0][X_WIRE_WIDTH-1:0] req_hpos,
    input  logic [1:0][Y_WIRE_WIDTH-1:0] req_vpos,
    input  logic [1:0][2:0]              req_rgb,
    output logic [1:0]                   req_ready,
    output logic                         push,
    output logic [X_WIRE_WIDTH-1:0]      hpos_write,
    output logic [Y_WIRE_WIDTH-1:0]      vpos_write,
    output logic [2:0]                   RGB_write,
    input  logic                         full,
    input  logic                         drop_clr,
    output logic [DROP_CNT_W-1:0]        drop_cnt,
    output logic [1:0]                   owner
);

    arb_state_t state;
    arb_state_t state_next;
    logic       rr;
    logic       rr_next;
    logic       sel;
    logic       on_screen;
    logic       accept;

    // Pick the requester that may use the port this cycle.
    always_comb begin
        sel = 1'b0;
        case (state)
            ST_BURST0: sel = 1'b0;
            ST_BURST1: sel = 1'b1;
            default: begin
                if (req_valid[0] && req_valid[1]) sel = rr;
                else if (req_valid[1])            sel = 1'b1;
                else                              sel = 1'b0;
            end
        endcase
    end

    assign hpos_write = req_hpos[sel];
    assign vpos_write = req_vpos[sel];
    assign RGB_write  = req_rgb[sel];

    pixel_clip #(
        .RESOLUTION_H (RESOLUTION_H),
        .RESOLUTION_V (RESOLUTION_V),
        .X_WIRE_WIDTH (X_WIRE_WIDTH),
        .Y_WIRE_WIDTH (Y_WIRE_WIDTH)
    ) u_clip (
        .hpos      (hpos_write),
        .vpos      (vpos_write),
        .on_screen (on_screen)
    );

    // Off-screen beats never reach the FIFO, so they are taken even when full.
    assign accept    = !rst && req_valid[sel] && (!on_screen || !full);
    assign push      = accept && on_screen;
    assign req_ready = accept ? (sel ? 2'b10 : 2'b01) : 2'b00;

    // Next state: only an accepted beat moves the arbiter; a stall keeps the lock.
    always_comb begin
        state_next = state;
        rr_next    = rr;
        if (accept) begin
            if (req_last[sel]) begin
                state_next = ST_IDLE;
                rr_next    = ~sel;
            end else if (state == ST_IDLE) begin
                state_next = sel ? ST_BURST1 : ST_BURST0;
            end
        end
    end

    // Arbiter state, round-robin pointer and registered owner flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            rr    <= 1'b0;
            owner <= 2'b00;
        end else begin
            state <= state_next;
            rr    <= rr_next;
            owner <= owner_of(state_next);
        end
    end

    // Saturating count of clipped beats; clear wins over a same-cycle drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop_clr) begin
            drop_cnt <= '0;
        end else if (accept && !on_screen && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: doc/pixel_write_arbiter.md
# pixel_write_arbiter

Shares the single push port of the pixel-write FIFO (`FIFO_top`: hpos/vpos/RGB entries) between two pixel producers: requester 0 (drawing engine) and requester 1 (host/debug writer). It applies round-robin arbitration with burst locking, clips off-screen coordinates before they consume FIFO space, and keeps a saturating count of dropped pixels. It sits between the producers and `FIFO_top`; the framebuffer side pops the FIFO as before.

## Interface
Parameters:
- `RESOLUTION_H`, 1280, visible width; valid x is 0..RESOLUTION_H-1
- `RESOLUTION_V`, 960, visible height; valid y is 0..RESOLUTION_V-1
- `H_FRONT`/`H_SYNC`/`H_BACK`, 80/136/216, horizontal timing; used only for width derivation
- `V_BOTTOM`/`V_SYNC`/`V_TOP`, 1/3/30, vertical timing; used only for width derivation
- `X_WIRE_WIDTH`, $clog2(RESOLUTION_H+H_FRONT+H_SYNC+H_BACK) = 11
- `Y_WIRE_WIDTH`, $clog2(RESOLUTION_V+V_BOTTOM+V_SYNC+V_TOP) = 10
- `DROP_CNT_W`, 16, width of the drop counter

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  synchronous reset, active-high
- `req_valid`  in  2  requester i offers a pixel
- `req_last`  in  2  beat i ends requester i's burst
- `req_hpos`  in  2×X_WIRE_WIDTH  x coordinate per requester
- `req_vpos`  in  2×Y_WIRE_WIDTH  y coordinate per requester
- `req_rgb`  in  2×3  colour per requester
- `req_ready`  out  2  beat i is consumed this cycle
- `push`  out  1  to FIFO_top push
- `hpos_write`  out  X_WIRE_WIDTH  to FIFO_top
- `vpos_write`  out  Y_WIRE_WIDTH  to FIFO_top
- `RGB_write`  out  3  to FIFO_top
- `full`  in  1  from FIFO_top
- `drop_clr`  in  1  clears the drop counter
- `drop_cnt`  out  DROP_CNT_W  count of clipped pixels (saturating)
- `owner`  out  2  one-hot current burst owner; 0 when IDLE

## Operation
- **FSM states:** IDLE, BURST0, BURST1. Round-robin pointer `rr`, 1 bit.
- **Selection.**
  - IDLE: the selected requester is the only valid one. If both are valid, it is requester `rr`.
  - BURSTn: the selected requester is n only. The other requester's `req_ready` is 0.
- **Clipping.** A beat is off-screen when hpos ≥ RESOLUTION_H or vpos ≥ RESOLUTION_V. Comparisons are unsigned at full port width.
- **Acceptance.** `req_ready[sel]` = valid & (off-screen | !full).
  - An on-screen accept drives `push`=1 with the selected data.
  - An off-screen accept drives `push`=0 and increments `drop_cnt`.
  - Off-screen beats are accepted even when `full`=1.
- **Transitions on an accepted beat.**
  - `last`=0 in IDLE: go to BURST<sel>.
  - `last`=1 in any state: go to or stay in IDLE, and set `rr` = ~sel.
- **No-accept cycles.** No state change when nothing is accepted. This includes a stalled beat held by `full` inside a burst: the burst stays locked.
- **drop_cnt.**
  - Saturates at all-ones.
  - `drop_clr` has priority over a simultaneous increment; the counter reads 0 the next cycle.
- **owner** is one-hot of the BURST state (bit n in BURSTn).

## Timing
- **Reset values:** state IDLE, `rr`=0, `drop_cnt`=0, `owner`=0. `push`=0 and `req_ready`=0 while `rst` is high, regardless of inputs.
- **Datapath latency:** zero. `push` and data are combinational from the selected requester and `full`. This ensures `push` is never asserted in a cycle where `full`=1.
- **Registered updates:** state, `rr` and `drop_cnt` update on the `clk` edge after the accepting cycle.
- **Reset mid-burst:** returns to IDLE. Any partially sent burst is abandoned, with no flush. FIFO contents are the FIFO's own concern.
- **Same-cycle events:** valid on both requesters together with `full` favours `rr`. The loser sees `req_ready`=0 even when its own beat is off-screen.

## Structure
- Shared package `fb_pkg`:
  - `pixel_t` struct (hpos, vpos, rgb)
  - the resolution and timing constants, plus the derived `X_WIRE_WIDTH` / `Y_WIRE_WIDTH`
  - the `arb_state_t` enum
- Sub-module `pixel_clip`: combinational on-screen check, parameterised by resolution. It is reused later by the drawing engine.
- Top level = FSM + mux + counter. Estimated 150–250 lines.

## Test plan
- **Single requester:** reset, then req0 streams 10 on-screen beats with `last` on beat 10 and `full`=0 → 10 pushes on consecutive cycles, data matches, `owner`=01 during beats 1–9, then IDLE with `rr`=1.
- **Round-robin:** both requesters hold single-beat (`last`=1) traffic → grants alternate 0,1,0,1…; a stalled req1 never waits more than 1 beat.
- **Burst lock:** req0 starts a 4-beat burst while req1 is valid → req1 gets no ready until req0's `last`; req1 then goes next.
- **Full stall:** `full`=1 mid-burst for 5 cycles → `push`=0 and `req_ready`=0 throughout, state unchanged; the push resumes in the cycle `full` drops.
- **Clipping:** beats (1280,0), (0,960), (2047,1023) with `full`=1 → all three are accepted with no push and `drop_cnt`=3. `drop_clr` together with a drop → `drop_cnt`=0. Preloading 0xFFFE and then sending 3 drops → 0xFFFF.
- **Reset mid-burst:** assert `rst` on beat 2 of a burst → next cycle shows IDLE, `owner`=0, `drop_cnt`=0, `rr`=0.
